// File: rtl/muldiv_unit_pkg.sv
// Shared RISC-V M-extension definitions: operation encoding and operand-class helpers.
package rvcpu;

    typedef enum logic [2:0] {
        MUL    = 3'b000,
        MULH   = 3'b001,
        MULHSU = 3'b010,
        MULHU  = 3'b011,
        DIV    = 3'b100,
        DIVU   = 3'b101,
        REM    = 3'b110,
        REMU   = 3'b111
    } muldiv_op_t;

    function automatic logic is_mul(input muldiv_op_t op);
        return ~op[2];
    endfunction

    function automatic logic is_signed_a(input muldiv_op_t op);
        return (op == MULH) || (op == MULHSU) || (op == DIV) || (op == REM);
    endfunction

    function automatic logic is_signed_b(input muldiv_op_t op);
        return (op == MULH) || (op == DIV) || (op == REM);
    endfunction

endpackage

// File: rtl/muldiv_unit_negate.sv
// Conditional two's-complement negate, used for operand magnitudes and result sign fixup.
module muldiv_negate #(
    parameter int Width = 32
) (
    input  logic [Width-1:0] value,
    input  logic             neg,
    output logic [Width-1:0] result
);

    assign result = neg ? (~value + Width'(1)) : value;

endmodule

// File: rtl/muldiv_unit.sv
// Iterative M-extension multiply/divide: shift-add multiply, restoring divide, one bit per cycle.
module muldiv_unit
    import rvcpu::*;
#(
    parameter int Width = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  muldiv_op_t       op,
    input  logic [Width-1:0] a,
    input  logic [Width-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [Width-1:0] res
);

    localparam int CntW = $clog2(Width);

    typedef logic [1:0] muldiv_state_t;
    localparam muldiv_state_t IDLE  = 2'd0;
    localparam muldiv_state_t CALC  = 2'd1;
    localparam muldiv_state_t FIXUP = 2'd2;
    localparam muldiv_state_t DONE  = 2'd3;

    muldiv_state_t      state;
    logic [CntW-1:0]    cnt;
    muldiv_op_t         op_q;
    logic               fix_neg_q;
    logic [2*Width-1:0] acc_q;
    logic [Width-1:0]   mcand_q;
    logic [Width:0]     rem_q;
    logic [Width-1:0]   res_q;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign res       = res_q;

    // Operand magnitudes; the most-negative value passes through as 2^(Width-1).
    logic             sign_a, sign_b;
    logic [Width-1:0] mag_a, mag_b;

    assign sign_a = is_signed_a(op) & a[Width-1];
    assign sign_b = is_signed_b(op) & b[Width-1];

    muldiv_negate #(.Width(Width)) u_neg_a (.value(a), .neg(sign_a), .result(mag_a));
    muldiv_negate #(.Width(Width)) u_neg_b (.value(b), .neg(sign_b), .result(mag_b));

    logic             accept, b_zero, ovf, early;
    logic [Width-1:0] early_res;

    assign accept    = in_valid & in_ready & ~flush;
    assign b_zero    = (b == '0);
    assign ovf       = ((op == DIV) || (op == REM)) && (a == {1'b1, {(Width-1){1'b0}}}) && (&b);
    assign early     = op[2] & (b_zero | ovf);
    assign early_res = b_zero ? (op[1] ? a : '1) : (op[1] ? '0 : a);

    // One multiply step: conditionally add the multiplicand into the high half, then shift right.
    logic [Width:0] mul_sum;
    assign mul_sum = {1'b0, acc_q[2*Width-1:Width]} + (acc_q[0] ? {1'b0, mcand_q} : '0);

    // One restoring-divide step: bring in the next dividend bit and trial-subtract the divisor.
    logic [Width:0]   div_shift;
    logic [Width+1:0] div_diff;
    logic             div_borrow;
    assign div_shift  = {rem_q[Width-1:0], acc_q[Width-1]};
    assign div_diff   = {1'b0, div_shift} - {2'b00, mcand_q};
    assign div_borrow = div_diff[Width+1];

    logic [2*Width-1:0] fix_in, fix_out;
    assign fix_in = is_mul(op_q) ? acc_q
                  : {{Width{1'b0}}, (op_q[1] ? rem_q[Width-1:0] : acc_q[Width-1:0])};

    muldiv_negate #(.Width(2*Width)) u_neg_fix (.value(fix_in), .neg(fix_neg_q), .result(fix_out));

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            op_q      <= MUL;
            fix_neg_q <= 1'b0;
            acc_q     <= '0;
            mcand_q   <= '0;
            rem_q     <= '0;
            res_q     <= '0;
        end else if (flush) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    op_q      <= op;
                    fix_neg_q <= (op == REM) ? sign_a : (sign_a ^ sign_b);
                    cnt       <= CntW'(Width - 1);
                    rem_q     <= '0;
                    if (is_mul(op)) begin
                        acc_q   <= {{Width{1'b0}}, mag_b};
                        mcand_q <= mag_a;
                    end else begin
                        acc_q   <= {{Width{1'b0}}, mag_a};
                        mcand_q <= mag_b;
                    end
                    if (early) begin
                        res_q <= early_res;
                        state <= DONE;
                    end else begin
                        state <= CALC;
                    end
                end
                CALC: begin
                    if (is_mul(op_q)) begin
                        acc_q <= {mul_sum, acc_q[Width-1:1]};
                    end else begin
                        rem_q <= div_borrow ? div_shift : div_diff[Width:0];
                        acc_q <= {{Width{1'b0}}, acc_q[Width-2:0], ~div_borrow};
                    end
                    if (cnt == '0) state <= FIXUP;
                    else           cnt   <= cnt - CntW'(1);
                end
                FIXUP: begin
                    if (op_q == MUL || !is_mul(op_q)) res_q <= fix_out[Width-1:0];
                    else                              res_q <= fix_out[2*Width-1:Width];
                    state <= DONE;
                end
                default: if (out_ready) state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed cases plus randomized ops against a longint model.
module tb_muldiv_unit;
    import rvcpu::*;

    localparam int W = 32;
    localparam logic [W-1:0] MIN = 32'h8000_0000;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         flush = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    muldiv_op_t   op = MUL;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] res;

    int checks = 0;
    int errors = 0;

    muldiv_unit #(.Width(W)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .op(op), .a(a), .b(b),
        .out_valid(out_valid), .out_ready(out_ready), .res(res)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference result straight from the M-extension arithmetic definitions.
    function automatic logic [W-1:0] model(input muldiv_op_t o, input logic [W-1:0] x, input logic [W-1:0] y);
        longint      sx, sy, ux, uy;
        logic [63:0] p;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        ux = longint'({32'd0, x});
        uy = longint'({32'd0, y});
        case (o)
            MUL:    begin p = 64'(sx * sy); return p[31:0];  end
            MULH:   begin p = 64'(sx * sy); return p[63:32]; end
            MULHSU: begin p = 64'(sx * uy); return p[63:32]; end
            MULHU:  begin p = 64'(ux) * 64'(uy); return p[63:32]; end
            DIV:    begin
                if (y == 0) return '1;
                if (x == MIN && y == '1) return MIN;
                p = 64'(sx / sy); return p[31:0];
            end
            DIVU:   return (y == 0) ? '1 : x / y;
            REM:    begin
                if (y == 0) return x;
                if (x == MIN && y == '1) return '0;
                p = 64'(sx % sy); return p[31:0];
            end
            default: return (y == 0) ? x : x % y;
        endcase
    endfunction

    function automatic bit is_early(input muldiv_op_t o, input logic [W-1:0] x, input logic [W-1:0] y);
        return o[2] && (y == 0 || ((o == DIV || o == REM) && x == MIN && y == '1));
    endfunction

    // Issue one op and wait for out_valid; lat is the edge index (after accept) at which it is first sampled high.
    task automatic issue(input muldiv_op_t o, input logic [W-1:0] x, input logic [W-1:0] y, output int lat);
        @(negedge clk);
        check("in_ready_before_issue", 64'(in_ready), 64'd1);
        op = o; a = x; b = y; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        op = muldiv_op_t'(3'($urandom_range(0, 7)));
        a = $urandom; b = $urandom;
        lat = 1;
        while (!out_valid && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic retire();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("in_ready_after_retire", 64'(in_ready), 64'd1);
        check("out_valid_after_retire", 64'(out_valid), 64'd0);
    endtask

    task automatic run(input string tag, input muldiv_op_t o, input logic [W-1:0] x, input logic [W-1:0] y);
        int lat;
        issue(o, x, y, lat);
        check({tag, "_lat"}, 64'(lat), is_early(o, x, y) ? 64'd1 : 64'(W + 2));
        check({tag, "_res"}, 64'(res), 64'(model(o, x, y)));
        retire();
    endtask

    initial begin
        int lat;
        int rose;
        logic [W-1:0] held;
        muldiv_op_t   ro;
        logic [W-1:0] ra, rb;

        #12;
        check("reset_in_ready", 64'(in_ready), 64'd1);
        check("reset_out_valid", 64'(out_valid), 64'd0);
        check("reset_res", 64'(res), 64'd0);
        @(negedge clk); rst_n = 1'b1;

        // Directed cases; expected values restated as literals for the spot checks.
        run("mul_neg1x7", MUL, 32'hFFFF_FFFF, 32'd7);
        check("mul_neg1x7_lit", 64'(model(MUL, 32'hFFFF_FFFF, 32'd7)), 64'hFFFF_FFF9);
        run("mulh_min", MULH, MIN, MIN);
        check("mulh_min_lit", 64'(model(MULH, MIN, MIN)), 64'h4000_0000);
        run("mulhsu", MULHSU, 32'hFFFF_FFFF, 32'd2);
        run("mulhu", MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run("div_m7_2", DIV, -32'sd7, 32'd2);
        check("div_m7_2_lit", 64'(model(DIV, -32'sd7, 32'd2)), 64'hFFFF_FFFD);
        run("rem_m7_2", REM, -32'sd7, 32'd2);
        check("rem_m7_2_lit", 64'(model(REM, -32'sd7, 32'd2)), 64'hFFFF_FFFF);
        run("divu_7_2", DIVU, 32'd7, 32'd2);
        run("remu_7_2", REMU, 32'd7, 32'd2);
        run("div_by0", DIV, 32'h1234, 32'd0);
        run("rem_by0", REM, 32'h1234, 32'd0);
        run("divu_by0", DIVU, 32'h1234, 32'd0);
        run("remu_by0", REMU, 32'h1234, 32'd0);
        run("div_ovf", DIV, MIN, 32'hFFFF_FFFF);
        run("rem_ovf", REM, MIN, 32'hFFFF_FFFF);
        run("divu_min_neg1", DIVU, MIN, 32'hFFFF_FFFF);

        // Backpressure: result held, no new request accepted.
        issue(MULHU, 32'hDEAD_BEEF, 32'h1234_5678, lat);
        check("bp_lat", 64'(lat), 64'(W + 2));
        held = res;
        check("bp_res", 64'(held), 64'(model(MULHU, 32'hDEAD_BEEF, 32'h1234_5678)));
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            check("bp_res_stable", 64'(res), 64'(held));
            check("bp_in_ready_low", 64'(in_ready), 64'd0);
            check("bp_out_valid_high", 64'(out_valid), 64'd1);
        end
        retire();

        // Flush in IDLE blocks the accept.
        @(negedge clk);
        op = MUL; a = 32'd9; b = 32'd9; in_valid = 1'b1; flush = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; flush = 1'b0;
        check("flush_idle_in_ready", 64'(in_ready), 64'd1);
        rose = 0;
        for (int i = 0; i < W + 4; i++) begin
            @(posedge clk); #1;
            if (out_valid) rose++;
        end
        check("flush_idle_no_result", 64'(rose), 64'd0);

        // Flush mid-CALC.
        @(negedge clk);
        op = DIV; a = 32'd1000; b = 32'd7; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("calc_in_ready_low", 64'(in_ready), 64'd0);
        repeat (5) @(posedge clk);
        @(negedge clk); flush = 1'b1;
        @(posedge clk); #1; flush = 1'b0;
        check("flush_calc_in_ready", 64'(in_ready), 64'd1);
        rose = 0;
        for (int i = 0; i < W + 4; i++) begin
            @(posedge clk); #1;
            if (out_valid) rose++;
        end
        check("flush_calc_no_result", 64'(rose), 64'd0);

        // Reset mid-operation.
        @(negedge clk);
        op = MULH; a = 32'h7FFF_FFFF; b = 32'h7FFF_FFFF; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (7) @(posedge clk);
        @(negedge clk); rst_n = 1'b0;
        #2;
        check("rst_mid_in_ready", 64'(in_ready), 64'd1);
        check("rst_mid_res", 64'(res), 64'd0);
        @(negedge clk); rst_n = 1'b1;
        rose = 0;
        for (int i = 0; i < W + 4; i++) begin
            @(posedge clk); #1;
            if (out_valid) rose++;
        end
        check("rst_mid_no_result", 64'(rose), 64'd0);
        run("mul_3x5", MUL, 32'd3, 32'd5);
        check("mul_3x5_lit", 64'(model(MUL, 32'd3, 32'd5)), 64'd15);

        // Randomized ops with a bias toward boundary operands.
        for (int n = 0; n < 200; n++) begin
            ro = muldiv_op_t'(3'($urandom_range(0, 7)));
            case ($urandom_range(0, 7))
                0:       ra = MIN;
                1:       ra = '1;
                default: ra = $urandom;
            endcase
            case ($urandom_range(0, 7))
                0:       rb = '0;
                1:       rb = '1;
                2:       rb = 32'($urandom_range(1, 15));
                default: rb = $urandom;
            endcase
            run("rand", ro, ra, rb);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
